// File: rtl/motor_cmd_framer_pkg.sv
// ============================================================================
// Module   : motor_cmd_pkg
// Brief    : Shared constants, FSM encoding and frame byte selection for the
//            motor command framer. MOTOR_CMD_FRAMER_CHECKSUM_EN adds byte 5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package motor_cmd_pkg;

  localparam int FRAME_LEN_BASE = 5;

  // Status byte layout
  localparam int PART_BIT = 7;
  localparam int RSVD_MSB = 6;
  localparam int RSVD_LSB = 5;
  localparam int MASK_LSB = 0;
  localparam int MASK_W   = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    START     = 3'd2,
    HOLD      = 3'd3,
    DRAIN     = 3'd4
  } framerState_t;

  function automatic logic rsvdClear(input logic [7:0] statusByte);
    return (statusByte[RSVD_MSB:RSVD_LSB] == 2'b00);
  endfunction

  // Byte 5 is the XOR checksum; it is only reached when the frame is 6 long.
  function automatic logic [7:0] frameByte(input logic [3:0]  motor,
                                           input logic [31:0] word,
                                           input logic [2:0]  idx);
    logic [7:0] hdr;
    hdr = {4'h0, motor};
    case (idx)
      3'd0:    frameByte = hdr;
      3'd1:    frameByte = word[7:0];
      3'd2:    frameByte = word[15:8];
      3'd3:    frameByte = word[23:16];
      3'd4:    frameByte = word[31:24];
      3'd5:    frameByte = hdr ^ word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
      default: frameByte = 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/motor_cmd_framer_status_rx.sv
// ============================================================================
// Module   : motor_status_rx
// Brief    : Decodes CPLD status bytes into the per-motor slot-occupied mask,
//            with stale-bit protection against status already in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_status_rx
  import motor_cmd_pkg::*;
#(
  parameter int NUM_MOTORS = 10
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  setEn,
  input  logic [3:0]            setMotor,
  output logic [NUM_MOTORS-1:0] pending,
  output logic                  status_valid,
  output logic                  status_err
);

  logic                  r_rxReadyQ;
  logic [NUM_MOTORS-1:0] r_stale;
  logic                  w_rise;
  logic                  w_fmtOk;
  logic                  w_part;
  logic [MASK_W-1:0]     w_mask;
  logic [NUM_MOTORS-1:0] w_nextPending;
  logic [NUM_MOTORS-1:0] w_nextStale;

  assign w_rise  = rx_ready & ~r_rxReadyQ;
  assign w_fmtOk = rsvdClear(rx_data);
  assign w_part  = rx_data[PART_BIT];
  assign w_mask  = rx_data[MASK_LSB +: MASK_W];

  // A completed frame overrides any status merge for its own motor.
  always_comb begin
    w_nextPending = pending;
    w_nextStale   = r_stale;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (w_rise && w_fmtOk && (i < 2 * MASK_W) && (w_part == (i >= MASK_W))) begin
        if (r_stale[i]) begin
          w_nextStale[i] = 1'b0;
        end else begin
          w_nextPending[i] = w_mask[i % MASK_W];
        end
      end
      if (setEn && (4'(i) == setMotor)) begin
        w_nextPending[i] = 1'b1;
        w_nextStale[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_rxReadyQ   <= 1'b0;
      r_stale      <= '0;
      pending      <= '1;
      status_valid <= 1'b0;
      status_err   <= 1'b0;
    end else begin
      r_rxReadyQ   <= rx_ready;
      r_stale      <= w_nextStale;
      pending      <= w_nextPending;
      status_valid <= w_rise & w_fmtOk;
      status_err   <= w_rise & ~w_fmtOk;
    end
  end

endmodule

`default_nettype wire

// File: rtl/motor_cmd_framer.sv
// ============================================================================
// Module   : motor_cmd_framer
// Brief    : Serialises motor commands into UART frames, holding each frame
//            until the CPLD reports the target slot free.
//            Define MOTOR_CMD_FRAMER_CHECKSUM_EN for a 6-byte frame with XOR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_cmd_framer
  import motor_cmd_pkg::*;
#(
  parameter int NUM_MOTORS = 10,
  parameter int DIV_W      = 15,
  parameter int STEP_W     = 17,
  parameter int START_TO   = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_motor,
  input  logic [DIV_W-1:0]      cmd_divider,
  input  logic [STEP_W-1:0]     cmd_steps,
  output logic                  cmd_err,
  output logic                  frame_done,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic [NUM_MOTORS-1:0] pending,
  output logic                  status_valid,
  output logic                  status_err
);

`ifdef MOTOR_CMD_FRAMER_CHECKSUM_EN
  localparam int c_frameLen = FRAME_LEN_BASE + 1;
`else
  localparam int c_frameLen = FRAME_LEN_BASE;
`endif
  localparam logic [2:0]     c_lastIdx   = 3'(c_frameLen - 1);
  localparam logic [4:0]     c_numMotors = 5'(NUM_MOTORS);
  localparam int             c_toW       = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [c_toW-1:0] c_toLast  = c_toW'(START_TO - 1);

  framerState_t     r_state;
  logic [3:0]       r_motor;
  logic [31:0]      r_word;
  logic [2:0]       r_byteIdx;
  logic [c_toW-1:0] r_toCnt;
  logic             w_badIdx;
  logic             w_lastByte;
  logic             w_frameEnd;

  assign w_badIdx   = ({1'b0, cmd_motor} >= c_numMotors);
  assign w_lastByte = (r_byteIdx == c_lastIdx);
  assign w_frameEnd = (r_state == DRAIN) && !tx_busy && w_lastByte;

  motor_status_rx #(
    .NUM_MOTORS (NUM_MOTORS)
  ) u_statusRx (
    .CLK          (CLK),
    .reset        (reset),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .setEn        (w_frameEnd),
    .setMotor     (r_motor),
    .pending      (pending),
    .status_valid (status_valid),
    .status_err   (status_err)
  );

  // tx_start/tx_data are loaded on the edge that enters START so the strobe
  // is exactly the START cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_motor    <= '0;
      r_word     <= '0;
      r_byteIdx  <= '0;
      r_toCnt    <= '0;
      cmd_ready  <= 1'b0;
      cmd_err    <= 1'b0;
      frame_done <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      cmd_err    <= 1'b0;
      frame_done <= 1'b0;
      tx_start   <= 1'b0;
      case (r_state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (w_badIdx) begin
              cmd_err <= 1'b1;
            end else begin
              r_motor   <= cmd_motor;
              r_word    <= {cmd_steps, cmd_divider};
              r_byteIdx <= 3'd0;
              r_state   <= WAIT_SLOT;
            end
          end
        end
        WAIT_SLOT: begin
          if (!pending[r_motor] && !tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= frameByte(r_motor, r_word, r_byteIdx);
            r_state  <= START;
          end
        end
        START: begin
          r_toCnt <= '0;
          r_state <= HOLD;
        end
        HOLD: begin
          if (tx_busy || (r_toCnt == c_toLast)) begin
            r_state <= DRAIN;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            if (w_lastByte) begin
              frame_done <= 1'b1;
              cmd_ready  <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_byteIdx <= r_byteIdx + 3'd1;
              tx_start  <= 1'b1;
              tx_data   <= frameByte(r_motor, r_word, r_byteIdx + 3'd1);
              r_state   <= START;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_motor_cmd_framer.sv
// ============================================================================
// Module   : tb_motor_cmd_framer
// Brief    : Directed scoreboard bench for motor_cmd_framer, with a simple
//            byte-transmitter model driving tx_busy.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_motor_cmd_framer;

  localparam int NUM_MOTORS = 10;
  localparam int DIV_W      = 15;
  localparam int STEP_W     = 17;
  localparam int START_TO   = 4;
`ifdef MOTOR_CMD_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN  = 6;
`else
  localparam int FRAME_LEN  = 5;
`endif

  logic                  CLK = 1'b0;
  logic                  reset = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [3:0]            cmd_motor = '0;
  logic [DIV_W-1:0]      cmd_divider = '0;
  logic [STEP_W-1:0]     cmd_steps = '0;
  logic                  cmd_err;
  logic                  frame_done;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic [7:0]            rx_data = '0;
  logic                  rx_ready = 1'b0;
  logic [NUM_MOTORS-1:0] pending;
  logic                  status_valid;
  logic                  status_err;

  int         nAsserts = 0;
  int         nFails = 0;
  int         nStart = 0;
  int         nDone = 0;
  int         cyc = 0;
  int         lastStartCyc = 0;
  int         lastGap = 0;
  int         busyCnt = 0;
  logic       ackEn = 1'b1;
  logic [7:0] expQ[$];

  motor_cmd_framer #(
    .NUM_MOTORS (NUM_MOTORS),
    .DIV_W      (DIV_W),
    .STEP_W     (STEP_W),
    .START_TO   (START_TO)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_motor    (cmd_motor),
    .cmd_divider  (cmd_divider),
    .cmd_steps    (cmd_steps),
    .cmd_err      (cmd_err),
    .frame_done   (frame_done),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .pending      (pending),
    .status_valid (status_valid),
    .status_err   (status_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Transmitter model: busy for 3 cycles after an accepted start strobe.
  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0;
      busyCnt <= 0;
    end else if (tx_start && ackEn) begin
      tx_busy <= 1'b1;
      busyCnt <= 3;
    end else if (busyCnt > 1) begin
      busyCnt <= busyCnt - 1;
    end else begin
      tx_busy <= 1'b0;
      busyCnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte monitor: every start strobe must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (tx_start) begin
      nStart++;
      lastGap = cyc - lastStartCyc;
      lastStartCyc = cyc;
      nAsserts++;
      assert (expQ.size() != 0) else begin
        nFails++;
        $error("FAIL txUnexpected: observed tx_data %0h with empty scoreboard, expected no tx_start", tx_data);
      end
      if (expQ.size() != 0) check("txByte", tx_data, expQ.pop_front());
    end
    if (frame_done) nDone++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pushFrame(input logic [3:0] m, input logic [DIV_W-1:0] d,
                           input logic [STEP_W-1:0] s);
    logic [31:0] w;
    logic [7:0]  csum;
    w    = {s, d};
    csum = {4'h0, m};
    expQ.push_back({4'h0, m});
    for (int k = 0; k < 4; k++) begin
      expQ.push_back(w[8*k +: 8]);
      csum = csum ^ w[8*k +: 8];
    end
`ifdef MOTOR_CMD_FRAMER_CHECKSUM_EN
    expQ.push_back(csum);
`endif
  endtask

  task automatic sendCmd(input logic [3:0] m, input logic [DIV_W-1:0] d,
                         input logic [STEP_W-1:0] s);
    int t;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("cmdReadyWait", cmd_ready, 1);
    cmd_motor   = m;
    cmd_divider = d;
    cmd_steps   = s;
    cmd_valid   = 1'b1;
    if (m < NUM_MOTORS) pushFrame(m, d, s);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic sendStatus(input logic [7:0] b, input logic expErr);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge CLK);
    check("statusValid", status_valid, !expErr);
    check("statusErr", status_err, expErr);
    rx_ready = 1'b0;
    @(negedge CLK);
  endtask

  task automatic waitDone(input int budget);
    int t;
    t = 0;
    while (!frame_done && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check("frameDone", frame_done, 1);
    @(negedge CLK);
  endtask

  initial begin
    int s0;
    int d0;
    int k;
    int t;
    logic [NUM_MOTORS-1:0] p0;

    tick(3);
    check("rstCmdReady", cmd_ready, 0);
    check("rstTxStart", tx_start, 0);
    check("rstTxData", tx_data, 0);
    check("rstCmdErr", cmd_err, 0);
    check("rstFrameDone", frame_done, 0);
    check("rstStatusValid", status_valid, 0);
    check("rstStatusErr", status_err, 0);
    check("rstPending", pending, {NUM_MOTORS{1'b1}});
    reset = 1'b0;
    tick(2);
    check("idleReady", cmd_ready, 1);

    // Basic frame after both halves report free
    sendStatus(8'h00, 1'b0);
    sendStatus(8'h80, 1'b0);
    check("pendingClear", pending, 0);
    s0 = nStart;
    d0 = nDone;
    sendCmd(4'd3, 15'h1234, 17'h00005);
    waitDone(200);
    check("t1Starts", nStart - s0, FRAME_LEN);
    check("t1DoneOnce", nDone - d0, 1);
    check("t1Pending3", pending[3], 1);

    // Slot busy: stale bit absorbs the first report, frame waits
    sendStatus(8'h08, 1'b0);
    check("t2Pending", pending, 10'h008);
    s0 = nStart;
    sendCmd(4'd3, 15'h0ABC, 17'h12345);
    tick(20);
    check("t2Held", nStart - s0, 0);
    check("t2NotReady", cmd_ready, 0);
    sendStatus(8'h00, 1'b0);
    waitDone(200);
    check("t2Starts", nStart - s0, FRAME_LEN);

    // Out-of-range motor index
    s0 = nStart;
    sendCmd(4'd12, 15'h0001, 17'h00001);
    check("t3Err", cmd_err, 1);
    check("t3NotReady", cmd_ready, 0);
    tick(1);
    check("t3ReadyBack", cmd_ready, 1);
    check("t3ErrPulse", cmd_err, 0);
    check("t3NoStart", nStart - s0, 0);

    // Transmitter never acknowledges: bytes advance on the start timeout
    ackEn = 1'b0;
    s0 = nStart;
    sendCmd(4'd5, 15'h7FFF, 17'h1FFFF);
    waitDone(300);
    check("t4Starts", nStart - s0, FRAME_LEN);
    check("t4Gap", lastGap, START_TO + 2);
    ackEn = 1'b1;

    // Malformed then valid upper-half status
    p0 = pending;
    sendStatus(8'hE1, 1'b1);
    check("t5Unchanged", pending, p0);
    sendStatus(8'h9F, 1'b0);
    check("t5Upper", pending[9:5], 5'h1F);
    check("t5Lower", pending[4:0], 5'h08);

    // Reset during byte 2
    s0 = nStart;
    sendCmd(4'd0, 15'h5555, 17'h0AAAA);
    k = 0;
    t = 0;
    while (k < 3 && t < 300) begin
      @(negedge CLK);
      t++;
      if (tx_start) k++;
    end
    check("t6Reached", k, 3);
    #1 reset = 1'b1;
    #1;
    check("t6TxStartDrop", tx_start, 0);
    check("t6TxData", tx_data, 0);
    check("t6Pending", pending, {NUM_MOTORS{1'b1}});
    expQ.delete();
    tick(2);
    reset = 1'b0;
    tick(2);
    s0 = nStart;
    sendCmd(4'd0, 15'h0001, 17'h00002);
    tick(20);
    check("t6Held", nStart - s0, 0);
    sendStatus(8'h00, 1'b0);
    waitDone(200);
    check("t6Starts", nStart - s0, FRAME_LEN);
    tick(3);
    check("queueEmpty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_cmd_framer.md
Name: motor_cmd_framer

Overview:
- Host-side initiator for the motor command link: the opposite end of the vertical-axis motor CPLD's UART command receiver.
- Serialises one motor command (index, divider, step count) into a UART byte frame and drives an async_transmitter-style byte interface.
- Decodes the CPLD's returned status bytes into a per-motor slot-occupied mask.
- Withholds each frame until the target motor's slot is free, so the CPLD never silently drops a command.

Parameters:
- NUM_MOTORS, 10, number of motor channels (max 16).
- DIV_W, 15, divider field width; fills word bits [DIV_W-1:0].
- STEP_W, 17, step-count field width; fills word bits [31:DIV_W]. DIV_W+STEP_W must equal 32.
- START_TO, 4, cycles to wait for tx_busy to rise after tx_start before treating the byte as accepted.

Ports:
- CLK, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: framer can accept a command.
- cmd_motor, in, 4: target motor index.
- cmd_divider, in, DIV_W: step-rate divider.
- cmd_steps, in, STEP_W: steps to go.
- cmd_err, out, 1: 1-cycle pulse, command dropped because index >= NUM_MOTORS.
- frame_done, out, 1: 1-cycle pulse, last byte of frame handed to the transmitter and drained.
- tx_data, out, 8: byte to transmit.
- tx_start, out, 1: 1-cycle start strobe.
- tx_busy, in, 1: transmitter busy.
- rx_data, in, 8: received status byte.
- rx_ready, in, 1: receiver data-ready level; edge-detected internally.
- pending, out, NUM_MOTORS: 1 = CPLD slot for that motor occupied.
- status_valid, out, 1: 1-cycle pulse when pending is updated.
- status_err, out, 1: 1-cycle pulse on a malformed status byte.

Behaviour:
- Reset values:
  - cmd_ready=0, tx_start=0, tx_data=0, cmd_err=0, frame_done=0, status_valid=0, status_err=0.
  - pending = all ones (unknown treated as occupied); stale mask = 0; FSM = IDLE.
- Frame format:
  - byte0 = {4'h0, motor}.
  - bytes1..4 = W = {steps, divider}, least significant byte first (W[7:0], W[15:8], W[23:16], W[31:24]).
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, capture the fields. Index >= NUM_MOTORS: pulse cmd_err next cycle, stay in IDLE. Otherwise go to WAIT_SLOT.
  - WAIT_SLOT: cmd_ready=0. Move to START when pending[motor]==0 and tx_busy==0.
  - START: drive tx_data with the current byte and tx_start=1 for exactly one cycle. Go to HOLD.
  - HOLD: wait for tx_busy=1, or START_TO cycles elapsed, then go to DRAIN.
  - DRAIN: wait for tx_busy=0. If more bytes remain, advance byte index and go to START. After the last byte: pulse frame_done, set pending[motor]=1, set stale[motor]=1, return to IDLE.
- Minimum gap between tx_start pulses is 3 cycles. Back-to-back commands to different free motors need no idle cycle beyond the return through IDLE.
- Status decode:
  - On rx_ready rising edge, check rx_data. bit7 = part (0 → motors 0..4, 1 → motors 5..9); bits6:5 must be 0; bits4:0 = mask.
  - Bits6:5 != 0: pulse status_err, pending unchanged.
  - Valid byte: update pending for that half and pulse status_valid the cycle after the edge.
  - Bits with stale=1 are not updated; their stale bit is cleared instead. This guards against a status byte already in flight before the command arrived.
  - Mask bits for indices >= NUM_MOTORS are ignored.
- Simultaneous events:
  - A status update and frame_done in the same cycle: frame_done's set of pending[motor] and stale[motor] wins for that motor.
  - Status decode runs independently of the TX FSM.
- Reset mid-frame:
  - The frame is abandoned and tx_start drops immediately.
  - A partially sent frame is not resumed; the CPLD resynchronises on its own.

Optional Feature:
- MOTOR_CMD_FRAMER_CHECKSUM_EN defined: 6-byte frame. byte5 = XOR of bytes0..4, sent through the same START/HOLD/DRAIN sequence. frame_done fires after byte5.
- Not defined: 5-byte frame exactly as above.

Decomposition:
- Package motor_cmd_pkg:
  - FRAME_LEN_BASE=5.
  - Status bit positions: PART_BIT=7, RSVD bits 6:5, MASK_LSB=0, MASK_W=5.
  - FSM state encoding: IDLE, WAIT_SLOT, START, HOLD, DRAIN.
- Sub-module motor_status_rx: rx_ready edge detect, format check, half-mask merge, stale handling. Outputs pending, status_valid, status_err. The framer FSM stays in the top.

Test Plan:
- Status bytes 8'h00 then 8'h80, then cmd motor=3, divider=15'h1234, steps=17'h00005 → bytes 03, 34, 92, 02, 00 with one tx_start each; frame_done once; pending[3]=1.
- Status 8'h08 (motor 3 busy), then cmd motor=3 → no tx_start. Next status 8'h00 → frame starts; first byte 03.
- cmd motor=12 → cmd_err pulse, no tx_start, cmd_ready high again the next cycle.
- tx_busy held low (transmitter never acknowledges) → each byte advances after START_TO cycles; 5 tx_start pulses total.
- Status 8'hE1 → status_err pulse, pending unchanged. Status 8'h9F → pending[9:5]=5'h1F.
- Reset asserted during byte 2 → tx_start=0 immediately, pending=all ones; after release, a new command waits for fresh status.
